// File: rtl/proc_control_unit.sv
//------------------------------------------------------------------------------
// proc_control_unit : T0-T3 instruction sequencer for the 16-bit datapath
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module proc_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [8:0] instr,
   output logic [7:0] r_in,
   output logic [7:0] r_out,
   output logic       a_in,
   output logic       g_in,
   output logic       g_out,
   output logic       din_out,
   output logic       add_sub,
   output logic       done,
   output logic       busy,
   output logic       illegal,
   output logic [8:0] ir_q
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_T1   = 2'd1;
   localparam logic [1:0] c_T2   = 2'd2;
   localparam logic [1:0] c_T3   = 2'd3;

   localparam logic [2:0] c_OP_MV  = 3'b000;
   localparam logic [2:0] c_OP_MVI = 3'b001;
   localparam logic [2:0] c_OP_ADD = 3'b010;
   localparam logic [2:0] c_OP_SUB = 3'b011;

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [2:0] w_op;
   logic [2:0] w_rx;
   logic [2:0] w_ry;
   logic [7:0] w_rx_dec;
   logic [7:0] w_ry_dec;

   assign w_op     = ir_q[8:6];
   assign w_rx     = ir_q[5:3];
   assign w_ry     = ir_q[2:0];
   assign w_rx_dec = 8'd1 << w_rx;
   assign w_ry_dec = 8'd1 << w_ry;

   // IR only loads in IDLE, so instr changes while busy are invisible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
         ir_q    <= 9'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == c_IDLE && run) begin
            ir_q <= instr;
         end
      end
   end

   always_comb begin
      w_next_state = c_IDLE;
      case (r_state)
         c_IDLE:  w_next_state = run ? c_T1 : c_IDLE;
         c_T1:    w_next_state = (w_op == c_OP_ADD || w_op == c_OP_SUB) ? c_T2 : c_IDLE;
         c_T2:    w_next_state = c_T3;
         c_T3:    w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      r_in    = 8'd0;
      r_out   = 8'd0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      din_out = 1'b0;
      add_sub = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      busy    = (r_state != c_IDLE);
      case (r_state)
         c_T1: begin
            case (w_op)
               c_OP_MV: begin
                  r_out = w_ry_dec;
                  r_in  = w_rx_dec;
                  done  = 1'b1;
               end
               c_OP_MVI: begin
                  din_out = 1'b1;
                  r_in    = w_rx_dec;
                  done    = 1'b1;
               end
               c_OP_ADD, c_OP_SUB: begin
                  r_out = w_rx_dec;
                  a_in  = 1'b1;
               end
               default: begin
                  done    = 1'b1;
                  illegal = 1'b1;
               end
            endcase
         end
         // T2/T3 are reachable only from add or sub.
         c_T2: begin
            r_out   = w_ry_dec;
            g_in    = 1'b1;
            add_sub = (w_op == c_OP_SUB);
         end
         c_T3: begin
            g_out = 1'b1;
            r_in  = w_rx_dec;
            done  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_proc_control_unit.sv
//------------------------------------------------------------------------------
// tb_proc_control_unit : directed self-checking bench for proc_control_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_proc_control_unit;

   localparam logic [7:0] c_F_AIN  = 8'h80;
   localparam logic [7:0] c_F_GIN  = 8'h40;
   localparam logic [7:0] c_F_GOUT = 8'h20;
   localparam logic [7:0] c_F_DIN  = 8'h10;
   localparam logic [7:0] c_F_SUB  = 8'h08;
   localparam logic [7:0] c_F_DONE = 8'h04;
   localparam logic [7:0] c_F_BUSY = 8'h02;
   localparam logic [7:0] c_F_ILL  = 8'h01;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [8:0] instr = 9'd0;
   logic [7:0] r_in;
   logic [7:0] r_out;
   logic       a_in;
   logic       g_in;
   logic       g_out;
   logic       din_out;
   logic       add_sub;
   logic       done;
   logic       busy;
   logic       illegal;
   logic [8:0] ir_q;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_bus  = 1'b0;

   always #5 clk = ~clk;

   proc_control_unit dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .instr   (instr),
      .r_in    (r_in),
      .r_out   (r_out),
      .a_in    (a_in),
      .g_in    (g_in),
      .g_out   (g_out),
      .din_out (din_out),
      .add_sub (add_sub),
      .done    (done),
      .busy    (busy),
      .illegal (illegal),
      .ir_q    (ir_q)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input logic [7:0] rin, input logic [7:0] rout,
                              input logic [7:0] flags);
      check_eq(tag, {8'd0, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, busy, illegal},
                    {8'd0, rin, rout, flags});
   endtask

   // At most one bus driver in any cycle.
   always @(negedge clk) begin
      if (chk_bus) begin
         check_eq("bus_one_driver", 32'($countones({r_out, g_out, din_out}) <= 1), 32'd1);
      end
   end

   initial begin
      // Reset asserted mid-cycle, outputs clear before any clock edge.
      #1 reset = 1'b1;
      #1;
      expect_outs("reset_async", 8'h00, 8'h00, 8'h00);
      check_eq("reset_irq", 32'(ir_q), 32'd0);

      @(negedge clk);
      reset   = 1'b0;
      chk_bus = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_outs("idle_run0", 8'h00, 8'h00, 8'h00);
         check_eq("idle_irq", 32'(ir_q), 32'd0);
      end

      // mvi R2 then mv R5,R2
      instr = 9'b001_010_000; run = 1'b1;
      @(negedge clk);
      expect_outs("mvi_t1", 8'h04, 8'h00, c_F_DIN | c_F_DONE | c_F_BUSY);
      check_eq("mvi_irq", 32'(ir_q), 32'(9'b001_010_000));
      instr = 9'b000_101_010;
      @(negedge clk);
      expect_outs("mvi_back_idle", 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      expect_outs("mv_t1", 8'h20, 8'h04, c_F_DONE | c_F_BUSY);
      run = 1'b0;
      @(negedge clk);
      expect_outs("mv_back_idle", 8'h00, 8'h00, 8'h00);

      // add R1,R2
      instr = 9'b010_001_010; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      expect_outs("add_t1", 8'h00, 8'h02, c_F_AIN | c_F_BUSY);
      @(negedge clk);
      expect_outs("add_t2", 8'h00, 8'h04, c_F_GIN | c_F_BUSY);
      @(negedge clk);
      expect_outs("add_t3", 8'h02, 8'h00, c_F_GOUT | c_F_DONE | c_F_BUSY);
      @(negedge clk);
      expect_outs("add_back_idle", 8'h00, 8'h00, 8'h00);

      // sub R4,R1 with run held and instr changed mid-instruction
      instr = 9'b011_100_001; run = 1'b1;
      @(negedge clk);
      expect_outs("sub_t1", 8'h00, 8'h10, c_F_AIN | c_F_BUSY);
      @(negedge clk);
      expect_outs("sub_t2", 8'h00, 8'h02, c_F_GIN | c_F_SUB | c_F_BUSY);
      instr = 9'b000_000_111;
      @(negedge clk);
      expect_outs("sub_t3", 8'h10, 8'h00, c_F_GOUT | c_F_DONE | c_F_BUSY);
      check_eq("sub_irq_held", 32'(ir_q), 32'(9'b011_100_001));
      @(negedge clk);
      expect_outs("sub_back_idle", 8'h00, 8'h00, 8'h00);
      check_eq("sub_irq_idle", 32'(ir_q), 32'(9'b011_100_001));
      @(negedge clk);
      expect_outs("mv_r0_r7_t1", 8'h01, 8'h80, c_F_DONE | c_F_BUSY);
      check_eq("mv_r0_r7_irq", 32'(ir_q), 32'(9'b000_000_111));
      run = 1'b0;
      @(negedge clk);
      expect_outs("mv_r0_r7_idle", 8'h00, 8'h00, 8'h00);

      // Illegal opcode
      instr = 9'b110_011_011; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      expect_outs("illegal_t1", 8'h00, 8'h00, c_F_DONE | c_F_BUSY | c_F_ILL);
      @(negedge clk);
      expect_outs("illegal_idle", 8'h00, 8'h00, 8'h00);

      // Reset during T2 of add R3,R5
      instr = 9'b010_011_101; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      expect_outs("add2_t1", 8'h00, 8'h08, c_F_AIN | c_F_BUSY);
      @(negedge clk);
      expect_outs("add2_t2", 8'h00, 8'h20, c_F_GIN | c_F_BUSY);
      #2 reset = 1'b1;
      #1;
      expect_outs("abort_async", 8'h00, 8'h00, 8'h00);
      check_eq("abort_irq", 32'(ir_q), 32'd0);
      @(negedge clk);
      expect_outs("abort_no_t3", 8'h00, 8'h00, 8'h00);

      // Release reset together with run: first edge samples run
      instr = 9'b001_111_000; run = 1'b1; reset = 1'b0;
      @(negedge clk);
      run = 1'b0;
      expect_outs("release_mvi_t1", 8'h80, 8'h00, c_F_DIN | c_F_DONE | c_F_BUSY);
      @(negedge clk);
      expect_outs("release_idle", 8'h00, 8'h00, 8'h00);

      chk_bus = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/proc_control_unit.md
# proc_control_unit

Instruction sequencer for the 16-bit processor datapath. It accepts a 9-bit instruction word, latches it into its own instruction register, and steps through timing states T0–T3. In each state it drives the register-load enables, the bus-driver selects and the ALU controls that move data between the eight general registers (built from the team's D-latch/flip-flop storage cells), the A/G registers and the shared 16-bit bus.

## Interface
Parameters:
- none. The block has exactly 8 registers, a 9-bit instruction word and a 3-bit opcode.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears the IR
- run  in  1  instruction-valid strobe, sampled only in IDLE
- instr  in  9  instruction word {op[8:6], rx[5:3], ry[2:0]}
- r_in  out  8  one-hot register load enables (bit n loads Rn from the bus)
- r_out  out  8  one-hot register bus-driver selects
- a_in  out  1  load the A register from the bus
- g_in  out  1  load the G register from the ALU result
- g_out  out  1  G drives the bus
- din_out  out  1  external DIN drives the bus (immediate)
- add_sub  out  1  ALU op: 0 = A+bus, 1 = A−bus
- done  out  1  high in the final cycle of an instruction
- busy  out  1  high in any state other than IDLE
- illegal  out  1  one-cycle pulse for an undefined opcode
- ir_q  out  9  current latched instruction

## Operation
- States: IDLE(T0), T1, T2, T3. The state and the IR are both registered.
- All control outputs are decoded combinationally from the state and ir_q. They change only after a clock edge or reset; they never depend on `run` or `instr`.
- IDLE: all outputs 0 except ir_q. If `run`=1 at a rising edge, then IR <= instr and the state goes to T1. If `run`=0, the state stays IDLE.
- op 000 `mv rx,ry`: in T1, r_out[ry]=1, r_in[rx]=1, done=1, then go to IDLE.
- op 001 `mvi rx,#D`: in T1, din_out=1, r_in[rx]=1, done=1, then go to IDLE. The datapath presents the immediate on DIN during T1.
- op 010 `add rx,ry`:
  - T1: r_out[rx]=1, a_in=1
  - T2: r_out[ry]=1, g_in=1, add_sub=0
  - T3: g_out=1, r_in[rx]=1, done=1, then go to IDLE
- op 011 `sub rx,ry`: same as add, with add_sub=1 in T2.
- op 100–111: in T1, done=1 and illegal=1, all enables 0, then go to IDLE. No register is modified.
- add_sub is 0 in every state except T2 of sub.
- Invariant: at most one bus driver is active per cycle. The popcount of {r_out, g_out, din_out} is ≤ 1.
- rx == ry is legal. For mv, the same bit is set in r_out and r_in.
- Width rules:
  - r_in and r_out are 3-to-8 one-hot decodes of rx or ry; all other bits are 0.
  - ALU arithmetic is 16-bit modulo 2^16 in the datapath. The controller carries no data.

## Timing
- Reset values: state=IDLE, ir_q=0, and r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, illegal all 0; busy=0.
- Reset takes effect immediately, without waiting for clk. Asserting it mid-instruction aborts: no further enables are issued, and the partial result in A/G is discarded.
- Latency from the `run`-sampling edge to done high:
  - mv, mvi and illegal: 1 cycle (done in T1)
  - add and sub: 3 cycles (done in T3)
- Busy cycles per instruction: 1 for mv, mvi and illegal; 3 for add and sub.
- The state returns to IDLE on the edge that ends the done cycle. `run` is ignored whenever busy=1; it is not queued.
- Maximum throughput is one instruction per 2 cycles for single-cycle ops (IDLE + T1) and one per 4 cycles for add/sub.
- `instr` must be stable only at the sampling edge. Changes to `instr` while busy have no effect on ir_q.
- reset released coincident with `run`=1: the first rising edge after release samples `run`.

## Test plan
- Reset then idle: assert reset mid-cycle → all outputs 0 immediately. Release with run=0 for 5 cycles → busy=0, ir_q=0.
- mvi then mv: run with instr=001_010_000 → next cycle din_out=1, r_in=8'h04, done=1. Then instr=000_101_010 → r_out=8'h04, r_in=8'h20, done=1.
- add R1,R2 (instr=010_001_010):
  - T1: r_out=8'h02, a_in=1
  - T2: r_out=8'h04, g_in=1, add_sub=0
  - T3: g_out=1, r_in=8'h02, done=1
  - busy is high for exactly 3 cycles.
- sub with run held high throughout and instr changed during T2 → add_sub=1 only in T2. The new instruction is not captured until IDLE, and ir_q is unchanged while busy.
- Illegal op 110_011_011 → T1 has done=1 and illegal=1 with all enables 0, and the state is IDLE the next cycle.
- Reset asserted during T2 of add → same-cycle return to all-zero outputs with no g_out/r_in pulse. Check the one-bus-driver invariant in every cycle of every test.
